led_fader: RTL and testbench
============================

// Module: led_fader
// PURPOSE
//  Downstream consumer of the LED rotation stage. Takes one-hot channel patterns through a
//  start_port/done_port handshake and drives the LED pins through per-channel PWM.
//  A newly selected channel lights at full brightness. Previously lit channels then decay
//  one level per prescaler tick, giving the rotating light a fading trail.
//  It sits between the pattern generator and the board LED pins (D1..D4).
// PARAMETERS
//  CHANNELS   4      number of LED channels / pattern bits
//  LEVEL_W    4      brightness bits per channel; MAX = 2**LEVEL_W-1
//  DIV_W      16     width of decay prescaler counter
//  DECAY_DIV  1000   clock cycles per decay tick; legal range 1..2**DIV_W-1 (0 is illegal)
// PORTS
//  clock        in   1          system clock; all state updates on its rising edge
//  reset        in   1          synchronous, active-low reset (0 = reset)
//  start_port   in   1          request to load pattern_in; sampled only in IDLE
//  pattern_in   in   CHANNELS   channels to set to MAX; all-zero pattern is legal (no-op load)
//  done_port    out  1          one-cycle pulse: load completed
//  led_out      out  CHANNELS   registered PWM outputs, one per channel
// BEHAVIOUR
//  Reset (reset=0 at an edge)
//   - level[*]=0, pwm_cnt=0, div_cnt=0, pat_q=0, state=IDLE, done_port=0, led_out=0.
//   - Reset mid-load discards the pending pattern; no done_port is issued.
//  FSM (IDLE -> LOAD -> DONE -> IDLE)
//   - IDLE:
//     - start_port=1 at edge n: capture pattern_in into pat_q, go to LOAD.
//     - start_port in LOAD or DONE is ignored.
//   - LOAD, edge n+1: for each i with pat_q[i]=1, set level[i]=MAX; go to DONE.
//   - DONE: done_port=1 for exactly the cycle after edge n+1; at edge n+2 go to IDLE.
//   - A continuously high start_port is accepted every 3 cycles.
//  Decay prescaler
//   - div_cnt counts 0..DECAY_DIV-1 and wraps.
//   - tick=1 on the cycle when div_cnt==DECAY_DIV-1.
//   - On a tick edge, every level[i]>0 decrements by 1; levels saturate at 0 (no underflow).
//   - Load and tick on the same edge: loaded channels take MAX; other channels still decay.
//  PWM
//   - pwm_cnt is free-running and wraps from all-ones to 0.
//   - led_out[i] <= (duty(level[i]) > pwm_cnt): one-cycle registered latency.
//   - level 0 means the output is never high.
// CONFIGURATION
//  LED_FADER_GAMMA_EN
//   - defined:
//     - pwm_cnt is 2*LEVEL_W bits; duty(l) = l*l (exact, 2*LEVEL_W bits).
//     - Result: perceptual quadratic fade; MAX gives 225/256 on-time.
//   - undefined:
//     - pwm_cnt is LEVEL_W bits; duty(l) = l.
//     - Result: linear fade; MAX gives 15/16 on-time.
// TESTING  (CHANNELS=4, LEVEL_W=4, DECAY_DIV=4, macro undefined unless stated)
//  1. reset=0 for 5 cycles with start_port=1, pattern_in=4'b1111
//     -> led_out=0 and done_port=0 on every cycle.
//  2. One-cycle start with pattern 4'b0001 at edge n
//     -> done_port high only in cycle n+1..n+2; level[0]=15.
//     -> led_out[0] high 15 of each 16 cycles; led_out[3:1] stay 0.
//  3. After test 2 with no further starts
//     -> level[0] drops by 1 every 4 cycles and reaches 0 after 60 cycles.
//     -> led_out[0] then stays 0; level never wraps to 15.
//  4. start_port held high for 9 cycles with pattern_in changing every cycle
//     -> exactly 3 loads (patterns sampled at edges 0, 3, 6); 3 done_port pulses.
//  5. Load 4'b0010 timed onto a tick edge while level[0]=5
//     -> level[1]=15 and level[0]=4 after that edge.
//  6. LED_FADER_GAMMA_EN defined; load 4'b0100 with DECAY_DIV=60000
//     -> led_out[2] high exactly 225 of 256 cycles per PWM period.

Source files
------------

// File: rtl/led_fader_if.sv
// Pattern handshake between the LED rotation stage and led_fader.
// The master drives start_port/pattern_in; the slave returns done_port.
interface led_fader_if #(
  parameter int unsigned CHANNELS = 4
);
  logic                start_port;
  logic [CHANNELS-1:0] pattern_in;
  logic                done_port;

  modport master (
    output start_port,
    output pattern_in,
    input  done_port
  );

  modport slave (
    input  start_port,
    input  pattern_in,
    output done_port
  );
endinterface

// File: rtl/led_fader.sv
// LED fader: loads one-hot channel patterns through a start/done handshake,
// sets the selected channels to full brightness and lets every lit channel
// decay one level per prescaler tick, driving the pins through per-channel PWM.
// Optional feature macro LED_FADER_GAMMA_EN: quadratic duty (l*l) over a
// 2*LEVEL_W-bit PWM counter instead of the linear duty over LEVEL_W bits.
module led_fader #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned LEVEL_W   = 4,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned DECAY_DIV = 1000   // 1..2**DIV_W-1
) (
  input  logic                clock,
  input  logic                reset,        // synchronous, active low
  led_fader_if.slave          hs,
  output logic [CHANNELS-1:0] led_out
);

`ifdef LED_FADER_GAMMA_EN
  localparam int unsigned PWM_W = 2 * LEVEL_W;
`else
  localparam int unsigned PWM_W = LEVEL_W;
`endif

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, next_state;
  logic [CHANNELS-1:0] pat_q;
  logic                load;
  logic                tick;
  logic [DIV_W-1:0]    div_cnt;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [LEVEL_W-1:0]  level [CHANNELS];

  // Brightness level to PWM compare threshold.
  function automatic logic [PWM_W-1:0] duty(input logic [LEVEL_W-1:0] l);
`ifdef LED_FADER_GAMMA_EN
    return PWM_W'(l) * PWM_W'(l);
`else
    return l;
`endif
  endfunction

  // Handshake state register and pattern capture on acceptance in IDLE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      pat_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && hs.start_port) begin
        pat_q <= hs.pattern_in;
      end
    end
  end

  // Next-state decode; done_port is a Moore output of the DONE state.
  always_comb begin
    next_state   = state;
    load         = 1'b0;
    hs.done_port = 1'b0;
    unique case (state)
      IDLE: if (hs.start_port) next_state = LOAD;
      LOAD: begin
        load       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        hs.done_port = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign tick = (div_cnt == DIV_LAST);

  // Decay prescaler: counts 0..DECAY_DIV-1 and wraps.
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Per-channel brightness: a load wins over decay, decay saturates at zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        level[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (load && pat_q[i]) begin
          level[i] <= '1;
        end else if (tick && level[i] != '0) begin
          level[i] <= level[i] - LEVEL_W'(1);
        end
      end
    end
  end

  // Free-running PWM counter, wraps from all-ones to zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  // Registered PWM compare per channel.
  always_ff @(posedge clock) begin
    if (!reset) begin
      led_out <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        led_out[i] <= (duty(level[i]) > pwm_cnt);
      end
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: a cycle model pushes the expected
// done_port/led_out for every edge into a scoreboard queue, popped and
// compared after the edge, plus directed checks on the scenario outcomes.
module tb_led_fader;

`ifdef LED_FADER_GAMMA_EN
  localparam int unsigned DIV     = 60000;
  localparam int unsigned PWM_MOD = 256;
`else
  localparam int unsigned DIV     = 4;
  localparam int unsigned PWM_MOD = 16;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] led_out;

  led_fader_if #(.CHANNELS(4)) hs ();

  led_fader #(
    .CHANNELS (4),
    .LEVEL_W  (4),
    .DIV_W    (16),
    .DECAY_DIV(DIV)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .hs     (hs),
    .led_out(led_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       done;
    logic [3:0] led;
  } exp_t;

  exp_t       sbq[$];
  int         errors = 0;
  int         checks = 0;

  // reference model state
  int         m_level[4];
  int         m_pwm   = 0;
  int         m_div   = 0;
  int         m_state = 0;   // 0 idle, 1 load, 2 done
  logic [3:0] m_pat   = '0;

  function automatic int mduty(input int l);
`ifdef LED_FADER_GAMMA_EN
    return l * l;
`else
    return l;
`endif
  endfunction

  task automatic step();
    exp_t e;
    exp_t got;
    int   nlev[4];
    int   nstate;
    bit   tick;
    tick = (m_div == DIV - 1);
    if (!reset) begin
      for (int i = 0; i < 4; i++) m_level[i] = 0;
      m_pwm = 0; m_div = 0; m_state = 0; m_pat = '0;
      e.done = 1'b0;
      e.led  = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        e.led[i] = (mduty(m_level[i]) > m_pwm);
        nlev[i] = m_level[i];
        if (m_state == 1 && m_pat[i]) nlev[i] = 15;
        else if (tick && nlev[i] > 0) nlev[i] = nlev[i] - 1;
      end
      for (int i = 0; i < 4; i++) m_level[i] = nlev[i];
      nstate = m_state;
      case (m_state)
        0: if (hs.start_port) begin nstate = 1; m_pat = hs.pattern_in; end
        1: nstate = 2;
        default: nstate = 0;
      endcase
      m_state = nstate;
      m_div   = tick ? 0 : m_div + 1;
      m_pwm   = (m_pwm + 1) % PWM_MOD;
      e.done  = (m_state == 2);
    end
    sbq.push_back(e);
    @(posedge clock);
    #1;
    got = sbq.pop_front();
    checks++;
    assert (hs.done_port === got.done) else begin
      errors++;
      $error("FAIL done_port: observed=%b expected=%b t=%0t", hs.done_port, got.done, $time);
    end
    checks++;
    assert (led_out === got.led) else begin
      errors++;
      $error("FAIL led_out: observed=%b expected=%b t=%0t", led_out, got.led, $time);
    end
  endtask

  task automatic check_int(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin : stim
    int  cnt;
    bit  found;
    for (int i = 0; i < 4; i++) m_level[i] = 0;
    hs.start_port = 1'b1;
    hs.pattern_in = 4'b1111;

    // 1: reset held with start asserted
    reset = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    hs.start_port = 1'b0;
    repeat (3) step();

    // 2: single-cycle start with channel 0
    hs.start_port = 1'b1;
    hs.pattern_in = 4'b0001;
    step();
    hs.start_port = 1'b0;
    hs.pattern_in = 4'b0000;
    step();
    check_int("level0_loaded", int'(dut.level[0]), 15);
    repeat (20) step();

    // 3: decay to zero without further starts, no wrap
    repeat (60) step();
`ifndef LED_FADER_GAMMA_EN
    check_int("level0_decayed", int'(dut.level[0]), 0);
    cnt = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (led_out[0]) cnt++;
    end
    check_int("led0_dark", cnt, 0);
`endif

    // 4: start held high for 9 cycles with a changing pattern
    cnt = 0;
    hs.start_port = 1'b1;
    for (int k = 0; k < 9; k++) begin
      hs.pattern_in = 4'(k + 1);
      step();
      if (hs.done_port) cnt++;
    end
    hs.start_port = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (hs.done_port) cnt++;
    end
    check_int("held_start_done_pulses", cnt, 3);
    repeat (70) step();

    // reset in the middle of a load discards it
    hs.start_port = 1'b1;
    hs.pattern_in = 4'b1000;
    step();
    hs.start_port = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (hs.done_port) cnt++;
    end
    check_int("reset_abort_done", cnt, 0);
    check_int("reset_abort_level3", int'(dut.level[3]), 0);

`ifndef LED_FADER_GAMMA_EN
    // 5: load timed onto a tick edge while level[0]=5
    hs.start_port = 1'b1;
    hs.pattern_in = 4'b0001;
    step();
    hs.start_port = 1'b0;
    step();
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_state == 0 && m_level[0] == 5 && m_div == DIV - 2) found = 1'b1;
      else step();
    end
    check_int("tick_align_found", int'(found), 1);
    hs.start_port = 1'b1;
    hs.pattern_in = 4'b0010;
    step();
    hs.start_port = 1'b0;
    step();
    check_int("tick_load_level1", int'(dut.level[1]), 15);
    check_int("tick_load_level0", int'(dut.level[0]), 4);
    repeat (10) step();
`else
    // 6: quadratic duty at full brightness
    hs.start_port = 1'b1;
    hs.pattern_in = 4'b0100;
    step();
    hs.start_port = 1'b0;
    repeat (4) step();
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (led_out[2]) cnt++;
    end
    check_int("gamma_on_time", cnt, 225);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
